nios_i2c_acc_sw_debounce: RTL and testbench

//  Upstream conditioning stage for the 10 slide switches. Synchronises each raw

---
 rtl/nios_i2c_acc_pkg.sv | 9 +
 rtl/nios_i2c_acc_debounce_bit.sv | 52 +++++
 rtl/nios_i2c_acc_sw_debounce.sv | 30 +++
 tb/tb_nios_i2c_acc_sw_debounce.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/nios_i2c_acc_pkg.sv
// Shared constants for the switch conditioning path.
// The top level and the testbench both read their defaults from here.
package nios_i2c_acc_pkg;

    localparam int SW_WIDTH           = 10;
    localparam int SW_SYNC_STAGES     = 2;
    localparam int SW_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/nios_i2c_acc_debounce_bit.sv
// One switch bit: a synchroniser chain, then a debounce counter that drives
// the registered clean level and a one-cycle change pulse.
module nios_i2c_acc_debounce_bit
    import nios_i2c_acc_pkg::*;
#(
    parameter int SYNC_STAGES     = SW_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_clean,
    output logic o_changed
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_clean;
    logic                   r_changed;
    logic                   w_sync_q;

    assign w_sync_q = r_sync[SYNC_STAGES-1];

    // The count saturates by accepting, so it never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync    <= '0;
            r_cnt     <= '0;
            r_clean   <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_changed <= 1'b0;
            if (w_sync_q == r_clean) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_clean   <= w_sync_q;
                r_cnt     <= '0;
                r_changed <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_clean   = r_clean;
    assign o_changed = r_changed;

endmodule

// File: rtl/nios_i2c_acc_sw_debounce.sv
// Slide-switch conditioning: WIDTH independent synchronise-and-debounce
// channels feeding the switch PIO, plus per-bit change strobes.
module nios_i2c_acc_sw_debounce
    import nios_i2c_acc_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int SYNC_STAGES     = SW_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_changed
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        nios_i2c_acc_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk       (clk),
            .reset     (reset),
            .i_raw     (sw_raw[g]),
            .o_clean   (sw_clean[g]),
            .o_changed (sw_changed[g])
        );
    end

endmodule

// File: tb/tb_nios_i2c_acc_sw_debounce.sv
// Bench for the switch debouncer with a short window, comparing every cycle
// against a history-based model plus hand-computed directed expectations.
module tb_nios_i2c_acc_sw_debounce;
    import nios_i2c_acc_pkg::*;

    localparam int W  = SW_WIDTH;
    localparam int S  = SW_SYNC_STAGES;
    localparam int DC = 4;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_clean;
    logic [W-1:0] sw_changed;

    always #5 clk = ~clk;

    nios_i2c_acc_sw_debounce #(
        .WIDTH           (W),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_raw     (sw_raw),
        .sw_clean   (sw_clean),
        .sw_changed (sw_changed)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: a raw level reaches the counter S edges after it is sampled unless a
    // reset edge intervened; a level is accepted once DC consecutive reset-free
    // edges all presented the opposite of the current clean value.
    logic [W-1:0] raw_q[$];
    bit           rst_q[$];
    logic [W-1:0] m_clean = '0;
    logic [W-1:0] m_chg   = '0;

    function automatic logic [W-1:0] sync_at(input int e);
        if (e - S < 0) return '0;
        for (int j = 1; j <= S; j++)
            if (rst_q[e-j]) return '0;
        return raw_q[e-S];
    endfunction

    always @(posedge clk) begin : model
        int           cur;
        logic [W-1:0] acc;
        raw_q.push_back(sw_raw);
        rst_q.push_back(reset);
        if (raw_q.size() > 16) begin
            void'(raw_q.pop_front());
            void'(rst_q.pop_front());
        end
        cur = raw_q.size() - 1;
        if (reset) begin
            m_clean = '0;
            m_chg   = '0;
            chk_en  = 1;
        end else begin
            acc = '1;
            for (int k = 0; k < DC; k++) begin
                if (cur - k < 0 || rst_q[cur-k]) acc = '0;
                else acc &= sync_at(cur - k) ^ m_clean;
            end
            m_chg   = acc;
            m_clean = m_clean ^ acc;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_clean", sw_clean, m_clean);
            check("model_changed", sw_changed, m_chg);
        end
    end

    logic [W-1:0] seen_chg = '0;

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            seen_chg |= sw_changed;
        end
    endtask

    initial begin
        // Reset with all switches high, then release.
        reset  = 1'b1;
        sw_raw = '1;
        step(3);
        check("rst_clean", sw_clean, '0);
        check("rst_changed", sw_changed, '0);
        reset = 1'b0;
        step(5);
        check("t1_pre_clean", sw_clean, '0);
        step(1);
        check("t1_clean", sw_clean, 10'h3FF);
        check("t1_pulse", sw_changed, 10'h3FF);
        step(1);
        check("t1_pulse_end", sw_changed, '0);

        // Clean single-bit edge.
        sw_raw = '0;
        step(10);
        sw_raw = 10'h001;
        step(5);
        check("t2_pre_clean", sw_clean, '0);
        step(1);
        check("t2_clean", sw_clean, 10'h001);
        check("t2_pulse", sw_changed, 10'h001);
        step(1);
        check("t2_pulse_end", sw_changed, '0);

        // Glitch shorter than the window, then a bounce before a real press.
        seen_chg = '0;
        sw_raw   = 10'h009;
        step(3);
        sw_raw = 10'h001;
        step(10);
        check("t3_glitch_clean", sw_clean, 10'h001);
        check("t3_glitch_no_pulse", seen_chg, '0);
        sw_raw = 10'h009;
        step(2);
        sw_raw = 10'h001;
        step(2);
        sw_raw = 10'h009;
        step(5);
        check("t3_pre_clean", sw_clean, 10'h001);
        step(1);
        check("t3_clean", sw_clean, 10'h009);
        check("t3_pulse", sw_changed, 10'h008);

        // Several bits at once.
        sw_raw = '0;
        step(10);
        sw_raw = 10'h2A5;
        step(5);
        check("t4_pre_clean", sw_clean, '0);
        step(1);
        check("t4_clean", sw_clean, 10'h2A5);
        check("t4_pulse", sw_changed, 10'h2A5);
        step(1);
        check("t4_pulse_end", sw_changed, '0);

        // Reset in the middle of a count on bit 5.
        seen_chg = '0;
        sw_raw   = 10'h285;
        step(4);
        reset = 1'b1;
        step(2);
        check("t5_rst_clean", sw_clean, '0);
        check("t5_no_pulse", seen_chg, '0);
        reset = 1'b0;
        step(5);
        check("t5_pre_clean", sw_clean, '0);
        step(1);
        check("t5_clean", sw_clean, 10'h285);
        check("t5_pulse", sw_changed, 10'h285);

        // Bit 9 toggling faster than the window.
        step(2);
        seen_chg = '0;
        repeat (13) begin
            sw_raw[9] = 1'b0;
            step(2);
            sw_raw[9] = 1'b1;
            step(2);
        end
        check("t6_clean9", sw_clean & 10'h200, 10'h200);
        check("t6_no_pulse9", seen_chg & 10'h200, '0);

        // Random bouncing with occasional resets.
        repeat (3000) begin
            reset  = ($urandom_range(0, 299) == 0);
            sw_raw = sw_raw ^ W'($urandom & $urandom & $urandom);
            step(1);
        end
        reset = 1'b0;
        step(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
